// File: rtl/xgmac_rx_pkg.sv
// Shared definitions for the XGMAC receive packet FIFO: stream widths, storage word
// layout, write FSM state encodings and small helper functions.
package xgmac_rx_pkg;

    localparam int AXIS_DW  = 64;
    localparam int AXIS_KW  = 8;
    localparam int WORD_W   = AXIS_DW + AXIS_KW + 1;
    localparam int LAST_BIT = 72;
    localparam int KEEP_LSB = 64;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_RECV    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    function automatic logic [WORD_W-1:0] packWord(input logic last,
                                                   input logic [AXIS_KW-1:0] keep,
                                                   input logic [AXIS_DW-1:0] data);
        return {last, keep, data};
    endfunction

    // A clear that lands on the same cycle as an event leaves the counter at one.
    function automatic logic [31:0] statNext(input logic [31:0] cur,
                                             input logic clr,
                                             input logic inc);
        logic [31:0] nxt;
        nxt = cur;
        if (clr)
            nxt = {31'd0, inc};
        else if (inc && (cur != 32'hFFFF_FFFF))
            nxt = cur + 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/xgmac_rx_pkt_fifo_if.sv
// AXI-Stream bundle used on both sides of the RX packet FIFO.
interface xgmac_rx_pkt_fifo_if;
    import xgmac_rx_pkg::*;

    logic [AXIS_DW-1:0] tdata;
    logic [AXIS_KW-1:0] tkeep;
    logic               tvalid;
    logic               tlast;
    logic               tuser;
    logic               tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast,
                    output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                    input tuser, output tready);
endinterface

// File: rtl/xgmac_rx_sdpram.sv
// Simple dual-port RAM, one write port and one read port with a registered 1-cycle read.
module xgmac_rx_sdpram #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset so the array and read register map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (re_i)
            rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xgmac_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO behind the 10G MAC: drops bad, runt and overflowing frames.
// Define RX_FIFO_STATS_EN to add saturating good/bad/overflow frame counters.
module xgmac_rx_pkt_fifo
    import xgmac_rx_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MIN_BEATS = 1
) (
    input  logic                 clk156,
    input  logic                 reset,
    xgmac_rx_pkt_fifo_if.slave   s_axis,
    xgmac_rx_pkt_fifo_if.master  m_axis,
    output logic                 drop_bad,
    output logic                 drop_ovf,
    output logic [ADDR_W:0]      pkt_count
`ifdef RX_FIFO_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_good,
    output logic [31:0]          stat_bad,
    output logic [31:0]          stat_ovf
`endif
);

    localparam int             DEPTH    = 1 << ADDR_W;
    localparam int             BCW      = $clog2(MIN_BEATS + 1);
    localparam logic [BCW-1:0] MIN_B    = BCW'(MIN_BEATS);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    wr_state_e         wr_state_q;
    logic [ADDR_W:0]   wr_ptr_q, wr_commit_q, rd_ptr_q, pkt_count_q, pkt_count_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic              wait_sof_q, ovf_q, drop_bad_q, drop_ovf_q, commit_q;
    logic              full, runt, wr_en;

    logic              avail, rd_en, adv_out, adv_ram, last_hs;
    logic              rv_q, m_valid_q;
    logic [WORD_W-1:0] ram_rdata, m_word_q;

    assign full       = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign beat_cnt_d = (beat_cnt_q == MIN_B) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign runt       = beat_cnt_d < MIN_B;
    assign wr_en      = s_axis.tvalid && !wait_sof_q && (wr_state_q != WR_DISCARD) && !full;

    // Write side: frames land past wr_commit and only become readable once the good tlast
    // moves wr_commit; any drop rewinds wr_ptr to wr_commit.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            wr_state_q  <= WR_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            beat_cnt_q  <= '0;
            wait_sof_q  <= 1'b1;
            ovf_q       <= 1'b0;
            drop_bad_q  <= 1'b0;
            drop_ovf_q  <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            drop_bad_q <= 1'b0;
            drop_ovf_q <= 1'b0;
            commit_q   <= 1'b0;
            if (s_axis.tvalid) begin
                case (wr_state_q)
                    WR_IDLE, WR_RECV: begin
                        if (wait_sof_q) begin
                            if (s_axis.tlast)
                                wait_sof_q <= 1'b0;
                            else
                                wr_state_q <= WR_DISCARD;
                        end else if (full) begin
                            if (s_axis.tlast) begin
                                wr_ptr_q   <= wr_commit_q;
                                drop_ovf_q <= 1'b1;
                                beat_cnt_q <= '0;
                                wr_state_q <= WR_IDLE;
                            end else begin
                                ovf_q      <= 1'b1;
                                wr_state_q <= WR_DISCARD;
                            end
                        end else if (s_axis.tlast) begin
                            beat_cnt_q <= '0;
                            wr_state_q <= WR_IDLE;
                            if (s_axis.tuser || runt) begin
                                wr_ptr_q   <= wr_commit_q;
                                drop_bad_q <= 1'b1;
                            end else begin
                                wr_ptr_q    <= wr_ptr_q + 1'b1;
                                wr_commit_q <= wr_ptr_q + 1'b1;
                                commit_q    <= 1'b1;
                            end
                        end else begin
                            wr_ptr_q   <= wr_ptr_q + 1'b1;
                            beat_cnt_q <= beat_cnt_d;
                            wr_state_q <= WR_RECV;
                        end
                    end
                    WR_DISCARD: begin
                        if (s_axis.tlast) begin
                            if (ovf_q) begin
                                wr_ptr_q   <= wr_commit_q;
                                drop_ovf_q <= 1'b1;
                                ovf_q      <= 1'b0;
                            end
                            wait_sof_q <= 1'b0;
                            beat_cnt_q <= '0;
                            wr_state_q <= WR_IDLE;
                        end
                    end
                    default: wr_state_q <= WR_IDLE;
                endcase
            end
        end
    end

    xgmac_rx_sdpram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk156),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (packWord(s_axis.tlast, s_axis.tkeep, s_axis.tdata)),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign avail   = rd_ptr_q != wr_commit_q;
    assign adv_out = !m_valid_q || m_axis.tready;
    assign adv_ram = !rv_q || adv_out;
    assign rd_en   = avail && adv_ram;
    assign last_hs = m_valid_q && m_axis.tready && m_word_q[LAST_BIT];

    // Two-stage read pipe: the RAM read register holds its word while the output
    // register is stalled, so no read is issued until one of them frees up.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            rv_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_word_q  <= '0;
        end else begin
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (adv_ram)
                rv_q <= rd_en;
            if (adv_out) begin
                m_valid_q <= rv_q;
                if (rv_q)
                    m_word_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (commit_q && !last_hs)
            pkt_count_d = pkt_count_q + 1'b1;
        else if (!commit_q && last_hs)
            pkt_count_d = pkt_count_q - 1'b1;
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset)
            pkt_count_q <= '0;
        else
            pkt_count_q <= pkt_count_d;
    end

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_word_q[AXIS_DW-1:0];
    assign m_axis.tkeep  = m_word_q[KEEP_LSB +: AXIS_KW];
    assign m_axis.tlast  = m_word_q[LAST_BIT];
    assign m_axis.tuser  = 1'b0;
    assign s_axis.tready = 1'b1;
    assign drop_bad      = drop_bad_q;
    assign drop_ovf      = drop_ovf_q;
    assign pkt_count     = pkt_count_q;

`ifdef RX_FIFO_STATS_EN
    logic [31:0] stat_good_q, stat_bad_q, stat_ovf_q;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
            stat_ovf_q  <= '0;
        end else begin
            stat_good_q <= statNext(stat_good_q, stat_clr, commit_q);
            stat_bad_q  <= statNext(stat_bad_q, stat_clr, drop_bad_q);
            stat_ovf_q  <= statNext(stat_ovf_q, stat_clr, drop_ovf_q);
        end
    end

    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
    assign stat_ovf  = stat_ovf_q;
`endif

endmodule

// File: tb/tb_xgmac_rx_pkt_fifo.sv
// Directed bench for xgmac_rx_pkt_fifo with a 16-beat buffer and 2-beat runt limit;
// counter ports are exercised when RX_FIFO_STATS_EN is defined.
module tb_xgmac_rx_pkt_fifo;

    localparam int AW   = 4;
    localparam int MINB = 2;

    typedef struct {
        int len;
        bit tuser;
        bit expGood;
        int expBad;
        int expOvf;
    } vec_t;

    logic          clk156 = 1'b0;
    logic          reset;
    logic          dropBad, dropOvf;
    logic [AW:0]   pktCount;
    logic          readyLevel, rndReady;
    logic [72:0]   expQ[$];
    int            checks = 0;
    int            passed = 0;
    int            nBad = 0;
    int            nOvf = 0;
    bit            pktRangeErr = 1'b0;
    bit            prevStall = 1'b0;
    logic [72:0]   prevWord = '0;
    vec_t          vecs[10];

`ifdef RX_FIFO_STATS_EN
    logic          statClr;
    logic [31:0]   statGood, statBad, statOvf;
`endif

    xgmac_rx_pkt_fifo_if s_if ();
    xgmac_rx_pkt_fifo_if m_if ();

    xgmac_rx_pkt_fifo #(
        .ADDR_W    (AW),
        .MIN_BEATS (MINB)
    ) dut (
        .clk156    (clk156),
        .reset     (reset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .drop_bad  (dropBad),
        .drop_ovf  (dropOvf),
        .pkt_count (pktCount)
`ifdef RX_FIFO_STATS_EN
        ,
        .stat_clr  (statClr),
        .stat_good (statGood),
        .stat_bad  (statBad),
        .stat_ovf  (statOvf)
`endif
    );

    always #3 clk156 = ~clk156;

    // Single driver for downstream ready: fixed level or a coin flip each cycle.
    always @(posedge clk156) begin
        #1;
        m_if.tready = rndReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [72:0] mkWord(input int id, input int b, input int len);
        logic       last;
        logic [7:0] keep;
        last = (b == len - 1);
        keep = last ? 8'h0F : 8'hFF;
        return {last, keep, 16'(id), 16'(b), 16'hA5C3 ^ 16'(id * 7 + b), 16'(b * 3 + 1)};
    endfunction

    task automatic pushFrame(input int len, input int id);
        for (int b = 0; b < len; b++)
            expQ.push_back(mkWord(id, b, len));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk156);
            #1;
        end
    endtask

    // Drives one frame back-to-back from posedge+1; tvalid drops after the last beat.
    task automatic applyStimulus(input int len, input bit tuser, input int id);
        logic [72:0] w;
        for (int b = 0; b < len; b++) begin
            w = mkWord(id, b, len);
            s_if.tvalid = 1'b1;
            s_if.tdata  = w[63:0];
            s_if.tkeep  = w[71:64];
            s_if.tlast  = w[72];
            s_if.tuser  = tuser && w[72];
            @(posedge clk156);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        waitCycles(4);
        while ((expQ.size() != 0 || pktCount != 0 || m_if.tvalid) && n < maxCycles) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain_done", {72'd0, (expQ.size() == 0 && pktCount == 0)}, 73'd1);
    endtask

    // Output monitor: scoreboard compare on handshake, AXI hold rule while stalled.
    always @(negedge clk156) begin
        logic [72:0] cur;
        logic [72:0] exp;
        cur = {m_if.tlast, m_if.tkeep, m_if.tdata};
        if (dropBad === 1'b1) nBad++;
        if (dropOvf === 1'b1) nOvf++;
        if (reset !== 1'b0) begin
            prevStall = 1'b0;
        end else begin
            if (pktCount > 16) pktRangeErr = 1'b1;
            if (prevStall) begin
                checkOutput("stall_tvalid", {72'd0, m_if.tvalid}, 73'd1);
                checkOutput("stall_word", cur, prevWord);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL spurious_beat: got %h, want no beat", cur);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("out_beat", cur, exp);
                end
            end
            prevStall = m_if.tvalid && !m_if.tready;
            prevWord  = cur;
        end
    end

    initial begin
        int b0, o0, goodE, badE, len;
        bit bad;

        vecs[0] = '{3,  1'b0, 1'b0, 0, 0};
        vecs[1] = '{8,  1'b0, 1'b1, 0, 0};
        vecs[2] = '{5,  1'b1, 1'b0, 1, 0};
        vecs[3] = '{3,  1'b0, 1'b1, 0, 0};
        vecs[4] = '{1,  1'b0, 1'b0, 1, 0};
        vecs[5] = '{2,  1'b0, 1'b1, 0, 0};
        vecs[6] = '{16, 1'b0, 1'b1, 0, 0};
        vecs[7] = '{17, 1'b0, 1'b0, 0, 1};
        vecs[8] = '{20, 1'b1, 1'b0, 0, 1};
        vecs[9] = '{4,  1'b0, 1'b1, 0, 0};

        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        readyLevel  = 1'b1;
        rndReady    = 1'b0;
`ifdef RX_FIFO_STATS_EN
        statClr     = 1'b0;
`endif
        waitCycles(3);
        @(negedge clk156);
        checkOutput("rst_tvalid",    {72'd0, m_if.tvalid}, 73'd0);
        checkOutput("rst_tdata",     {9'd0, m_if.tdata},   73'd0);
        checkOutput("rst_pkt_count", {68'd0, pktCount},    73'd0);
        checkOutput("rst_drop_bad",  {72'd0, dropBad},     73'd0);
        checkOutput("rst_drop_ovf",  {72'd0, dropOvf},     73'd0);
        @(posedge clk156);
        #1;
        reset = 1'b0;
        waitCycles(2);

        // First frame after reset is swallowed by the start-of-frame wait without a pulse.
        for (int v = 0; v < 10; v++) begin
            b0 = nBad;
            o0 = nOvf;
            if (vecs[v].expGood) pushFrame(vecs[v].len, 100 + v);
            applyStimulus(vecs[v].len, vecs[v].tuser, 100 + v);
            waitDrain(200);
            checkOutput($sformatf("vec%0d_drop_bad", v), 73'(nBad - b0), 73'(vecs[v].expBad));
            checkOutput($sformatf("vec%0d_drop_ovf", v), 73'(nOvf - o0), 73'(vecs[v].expOvf));
            checkOutput($sformatf("vec%0d_pkt_count", v), {68'd0, pktCount}, 73'd0);
        end

        // Commit-to-output latency: pkt_count one edge after commit, tvalid two.
        pushFrame(4, 200);
        applyStimulus(4, 1'b0, 200);
        @(negedge clk156);
        checkOutput("lat_e0_pkt",    {68'd0, pktCount},    73'd0);
        checkOutput("lat_e0_tvalid", {72'd0, m_if.tvalid}, 73'd0);
        @(negedge clk156);
        checkOutput("lat_e1_pkt",    {68'd0, pktCount},    73'd1);
        checkOutput("lat_e1_tvalid", {72'd0, m_if.tvalid}, 73'd0);
        @(negedge clk156);
        checkOutput("lat_e2_tvalid", {72'd0, m_if.tvalid}, 73'd1);
        @(posedge clk156);
        #1;
        waitDrain(100);

        // Overflow while stalled: second 10-beat frame cannot fit behind the first.
        readyLevel = 1'b0;
        waitCycles(2);
        b0 = nBad;
        o0 = nOvf;
        pushFrame(10, 300);
        applyStimulus(10, 1'b0, 300);
        applyStimulus(10, 1'b0, 301);
        waitCycles(4);
        checkOutput("ovf_drop_ovf",  73'(nOvf - o0),       73'd1);
        checkOutput("ovf_drop_bad",  73'(nBad - b0),       73'd0);
        checkOutput("ovf_pkt_count", {68'd0, pktCount},    73'd1);
        checkOutput("ovf_tvalid",    {72'd0, m_if.tvalid}, 73'd1);
        readyLevel = 1'b1;
        waitDrain(100);

        // Reset lands on beat 3 of 6 and lifts before beat 5; the tail must vanish silently.
        b0 = nBad;
        o0 = nOvf;
        for (int b = 0; b < 6; b++) begin
            logic [72:0] w;
            if (b == 4) reset = 1'b0;
            w = mkWord(400, b, 6);
            s_if.tvalid = 1'b1;
            s_if.tdata  = w[63:0];
            s_if.tkeep  = w[71:64];
            s_if.tlast  = w[72];
            s_if.tuser  = 1'b0;
            if (b == 2) begin
                #1;
                reset = 1'b1;
            end
            @(posedge clk156);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        waitCycles(6);
        checkOutput("rstmid_pkt_count", {68'd0, pktCount},    73'd0);
        checkOutput("rstmid_tvalid",    {72'd0, m_if.tvalid}, 73'd0);
        pushFrame(3, 401);
        applyStimulus(3, 1'b0, 401);
        waitDrain(100);
        checkOutput("rstmid_drop_bad", 73'(nBad - b0), 73'd0);
        checkOutput("rstmid_drop_ovf", 73'(nOvf - o0), 73'd0);

        // Random ready with pairs of back-to-back frames that always fit the buffer.
        rndReady = 1'b1;
`ifdef RX_FIFO_STATS_EN
        statClr = 1'b1;
        waitCycles(1);
        statClr = 1'b0;
`endif
        b0 = nBad;
        o0 = nOvf;
        goodE = 0;
        badE  = 0;
        for (int i = 0; i < 40; i += 2) begin
            for (int k = 0; k < 2; k++) begin
                len = ((i + k) * 5) % 7 + 1;
                bad = ((i + k) % 5 == 3);
                if (!bad && len >= MINB) begin
                    pushFrame(len, 1000 + i + k);
                    goodE++;
                end else begin
                    badE++;
                end
            end
            for (int k = 0; k < 2; k++)
                applyStimulus(((i + k) * 5) % 7 + 1, ((i + k) % 5 == 3), 1000 + i + k);
            waitDrain(400);
        end
        checkOutput("rnd_drop_bad", 73'(nBad - b0), 73'(badE));
        applyStimulus(17, 1'b0, 2000);
        waitDrain(100);
        checkOutput("rnd_drop_ovf", 73'(nOvf - o0), 73'd1);
        rndReady = 1'b0;
`ifdef RX_FIFO_STATS_EN
        checkOutput("stat_good", {41'd0, statGood}, 73'(goodE));
        checkOutput("stat_bad",  {41'd0, statBad},  73'(badE));
        checkOutput("stat_ovf",  {41'd0, statOvf},  73'd1);
        statClr = 1'b1;
        waitCycles(1);
        statClr = 1'b0;
        checkOutput("stat_clr_good", {41'd0, statGood}, 73'd0);
        checkOutput("stat_clr_bad",  {41'd0, statBad},  73'd0);
        checkOutput("stat_clr_ovf",  {41'd0, statOvf},  73'd0);
`endif
        checkOutput("pkt_count_range", {72'd0, pktRangeErr}, 73'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
